// File: rtl/core_seq_if.sv
// rtl/core_seq_if.sv - Control and instruction bundle between core_seq and the PE core; err exists only with CORE_SEQ_WATCHDOG_EN
interface core_seq_if;
  logic        start;
  logic [3:0]  num_kij;
  logic [10:0] num_nij;
  logic        mode_in;
  logic        ofifo_valid;
  logic [33:0] inst;
  logic        mode;
  logic        sel;
  logic        busy;
  logic        done;
`ifdef CORE_SEQ_WATCHDOG_EN
  logic        err;
`endif

  // Sequencer side: takes run parameters and the ofifo flag, drives the core
  modport master (
    input  start, num_kij, num_nij, mode_in, ofifo_valid,
    output inst, mode, sel, busy, done
`ifdef CORE_SEQ_WATCHDOG_EN
    , output err
`endif
  );

  // Core / host side: sees the instruction stream, supplies parameters
  modport slave (
    output start, num_kij, num_nij, mode_in, ofifo_valid,
    input  inst, mode, sel, busy, done
`ifdef CORE_SEQ_WATCHDOG_EN
    , input err
`endif
  );
endinterface

// File: rtl/core_seq.sv
// rtl/core_seq.sv - Layer-run sequencer issuing core instruction words; optional DRAIN watchdog via CORE_SEQ_WATCHDOG_EN
module core_seq #(
  parameter int row    = 2,
  parameter int col    = 2,
  parameter int W_BASE = 1024
) (
  input logic        clk,
  input logic        reset,
  core_seq_if.master bus
);

  localparam logic [33:0] IDLE_WORD = 34'h1_800C_0000;
  localparam logic [11:0] COL_W     = 12'(col);
  localparam logic [11:0] LOAD_LAST = 12'(row + col - 1);

  typedef enum logic [2:0] {IDLE, WFETCH, WLOAD, EXEC, DRAIN, SWAP, FIN} state_t;

  state_t      state, state_d;
  logic [3:0]  kij, kij_d;
  logic [3:0]  kij_n, kij_n_d;
  logic [10:0] nij_n, nij_n_d;
  logic [11:0] cnt, cnt_d;
  logic [10:0] dcnt, dcnt_d;
  logic        sel_q, sel_d;
  logic        mode_q, mode_d;
  logic [33:0] inst_q, inst_d;
  logic        busy_q, done_q;
  logic        pop;
  logic [10:0] w_addr;
`ifdef CORE_SEQ_WATCHDOG_EN
  logic [9:0]  wd, wd_d;
  logic        err_q, err_d;
`endif

  // Weight address for the fetch cycle being issued next
  assign w_addr = 11'(W_BASE) + 11'(int'(kij_d) * col) + cnt_d[10:0];

  // Next-state, counter and parameter-latch logic
  always_comb begin
    state_d = state;
    kij_d   = kij;
    kij_n_d = kij_n;
    nij_n_d = nij_n;
    cnt_d   = cnt;
    dcnt_d  = dcnt;
    sel_d   = sel_q;
    mode_d  = mode_q;
    pop     = 1'b0;
`ifdef CORE_SEQ_WATCHDOG_EN
    wd_d    = (state == DRAIN) ? wd : 10'd0;
    err_d   = err_q;
`endif
    case (state)
      IDLE: begin
        if (bus.start) begin
          kij_n_d = (bus.num_kij > 4'd9) ? 4'd9 : bus.num_kij;
          nij_n_d = bus.num_nij;
          mode_d  = bus.mode_in;
          kij_d   = 4'd0;
          cnt_d   = 12'd0;
          dcnt_d  = 11'd0;
`ifdef CORE_SEQ_WATCHDOG_EN
          err_d   = 1'b0;
`endif
          state_d = (bus.num_kij == 4'd0 || bus.num_nij == 11'd0) ? FIN : WFETCH;
        end
      end
      WFETCH: begin
        if (cnt == COL_W) begin
          cnt_d   = 12'd0;
          state_d = WLOAD;
        end else begin
          cnt_d = cnt + 12'd1;
        end
      end
      WLOAD: begin
        if (cnt == LOAD_LAST) begin
          cnt_d   = 12'd0;
          state_d = EXEC;
        end else begin
          cnt_d = cnt + 12'd1;
        end
      end
      EXEC: begin
        if (cnt == {1'b0, nij_n}) begin
          cnt_d   = 12'd0;
          dcnt_d  = 11'd0;
          state_d = DRAIN;
        end else begin
          cnt_d = cnt + 12'd1;
        end
      end
      DRAIN: begin
        if (bus.ofifo_valid) begin
          pop    = 1'b1;
          dcnt_d = dcnt + 11'd1;
`ifdef CORE_SEQ_WATCHDOG_EN
          wd_d   = 10'd0;
`endif
          if (dcnt == nij_n - 11'd1) state_d = SWAP;
        end
`ifdef CORE_SEQ_WATCHDOG_EN
        else if (wd == 10'd1023) begin
          err_d   = 1'b1;
          wd_d    = 10'd0;
          state_d = FIN;
        end else begin
          wd_d = wd + 10'd1;
        end
`endif
      end
      SWAP: begin
        sel_d   = ~sel_q;
        kij_d   = kij + 4'd1;
        state_d = (kij + 4'd1 == kij_n) ? FIN : WFETCH;
      end
      FIN: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Instruction word for the next cycle: a pop decided now, else decoded from next state
  always_comb begin
    inst_d = IDLE_WORD;
    if (pop) begin
      inst_d[33]    = (kij != 4'd0);
      inst_d[32]    = 1'b0;
      inst_d[31]    = 1'b0;
      inst_d[30:20] = dcnt;
      inst_d[6]     = 1'b1;
    end else begin
      case (state_d)
        WFETCH: begin
          if (cnt_d < COL_W) begin
            inst_d[19]   = 1'b0;
            inst_d[17:7] = w_addr;
          end
          if (cnt_d != 12'd0) inst_d[2] = 1'b1;
        end
        WLOAD: begin
          inst_d[3] = 1'b1;
          inst_d[0] = 1'b1;
        end
        EXEC: begin
          if (cnt_d < {1'b0, nij_n_d}) begin
            inst_d[19]   = 1'b0;
            inst_d[17:7] = cnt_d[10:0];
          end
          if (cnt_d != 12'd0) inst_d[3:1] = 3'b111;
        end
        default: ;
      endcase
    end
    inst_d[4] = sel_d;
  end

  // State, counters and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      kij    <= 4'd0;
      kij_n  <= 4'd0;
      nij_n  <= 11'd0;
      cnt    <= 12'd0;
      dcnt   <= 11'd0;
      sel_q  <= 1'b0;
      mode_q <= 1'b0;
      inst_q <= IDLE_WORD;
      busy_q <= 1'b0;
      done_q <= 1'b0;
`ifdef CORE_SEQ_WATCHDOG_EN
      wd     <= 10'd0;
      err_q  <= 1'b0;
`endif
    end else begin
      state  <= state_d;
      kij    <= kij_d;
      kij_n  <= kij_n_d;
      nij_n  <= nij_n_d;
      cnt    <= cnt_d;
      dcnt   <= dcnt_d;
      sel_q  <= sel_d;
      mode_q <= mode_d;
      inst_q <= inst_d;
      busy_q <= (state_d != IDLE);
      done_q <= (state_d == FIN);
`ifdef CORE_SEQ_WATCHDOG_EN
      wd     <= wd_d;
      err_q  <= err_d;
`endif
    end
  end

  assign bus.inst = inst_q;
  assign bus.mode = mode_q;
  assign bus.sel  = sel_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
`ifdef CORE_SEQ_WATCHDOG_EN
  assign bus.err  = err_q;
`endif

endmodule

// File: tb/tb_core_seq.sv
// tb/tb_core_seq.sv - Self-checking bench for core_seq; watchdog case built with CORE_SEQ_WATCHDOG_EN
module tb_core_seq;
  localparam int ROW = 2;
  localparam int COL = 2;
  localparam int WB  = 1024;
  localparam logic [33:0] IDLE_WORD = 34'h1_800C_0000;

  typedef struct {
    int kij;
    int nij;
    int pat;
    bit mode;
    bit poke;
    int writes;
    int busy;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  core_seq_if bus();

  core_seq #(.row(ROW), .col(COL), .W_BASE(WB)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int exp_x[$];
  int exp_p[$];
  int busy_cnt, done_cnt, exec_cnt, load_cnt, l0wr_cnt, wr_cnt, rd_stray;
  logic prev_valid = 1'b0;
  logic exp_sel = 1'b0;
  logic [5:0] pat6 = 6'b110101;
  vec_t vecs[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic int eff_kij(input int kij, input int nij);
    int k;
    k = (kij > 9) ? 9 : kij;
    return (nij == 0) ? 0 : k;
  endfunction

  task automatic push_run(input int kij, input int nij, input bit with_writes);
    int k;
    k = eff_kij(kij, nij);
    for (int p = 0; p < k; p++) begin
      for (int i = 0; i < COL; i++) exp_x.push_back(WB + p * COL + i);
      for (int j = 0; j < nij; j++) exp_x.push_back(j);
      if (with_writes)
        for (int j = 0; j < nij; j++) exp_p.push_back(((p != 0) ? 2048 : 0) + j);
    end
  endtask

  task automatic mon();
    if (bus.busy === 1'b1) busy_cnt++;
    if (bus.done === 1'b1) done_cnt++;
    if (bus.inst[1] === 1'b1) exec_cnt++;
    if (bus.inst[0] === 1'b1) load_cnt++;
    if (bus.inst[2] === 1'b1) l0wr_cnt++;
    if (bus.inst[19] === 1'b0) begin
      chk("xmem_wen", 64'(bus.inst[18]), 64'(1));
      if (exp_x.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL xmem_unexpected actual=%0d required=none", bus.inst[17:7]);
      end else chk("xmem_addr", 64'(bus.inst[17:7]), 64'(exp_x.pop_front()));
    end
    if (bus.inst[32] === 1'b0) begin
      wr_cnt++;
      chk("pmem_wen", 64'(bus.inst[31]), 64'(0));
      chk("ofifo_rd", 64'(bus.inst[6]), 64'(1));
      chk("pop_after_valid", 64'(prev_valid), 64'(1));
      if (exp_p.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL pmem_unexpected actual=%0d required=none", bus.inst[30:20]);
      end else chk("pmem_acc_addr", 64'({bus.inst[33], bus.inst[30:20]}), 64'(exp_p.pop_front()));
    end else if (bus.inst[6] === 1'b1) rd_stray++;
    prev_valid = bus.ofifo_valid;
  endtask

  task automatic tick();
    @(negedge clk);
    mon();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    busy_cnt = 0; done_cnt = 0; exec_cnt = 0; load_cnt = 0;
    l0wr_cnt = 0; wr_cnt = 0; rd_stray = 0;
  endtask

  task automatic run_case(input vec_t v, input int idx);
    bit seen;
    int k;
    logic [33:0] w;
    k = eff_kij(v.kij, v.nij);
    bus.num_kij = 4'(v.kij);
    bus.num_nij = 11'(v.nij);
    bus.mode_in = v.mode;
    bus.ofifo_valid = 1'b0;
    push_run(v.kij, v.nij, 1'b1);
    clr();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    seen = 1'b0;
    for (int cyc = 0; cyc < 3000 && !seen; cyc++) begin
      if (bus.done === 1'b1) seen = 1'b1;
      else begin
        case (v.pat)
          0: bus.ofifo_valid = 1'b1;
          1: bus.ofifo_valid = pat6[cyc % 6];
          default: bus.ofifo_valid = 1'($urandom_range(0, 1));
        endcase
        if (v.poke && cyc == 4) begin
          bus.start = 1'b1;
          bus.num_nij = 11'd7;
          bus.num_kij = 4'd4;
          bus.mode_in = ~v.mode;
        end
        if (v.poke && cyc == 5) bus.start = 1'b0;
        tick();
      end
    end
    chk($sformatf("v%0d_done_seen", idx), 64'(seen), 64'(1));
    bus.ofifo_valid = 1'b0;
    tick();
    tick();
    if (k[0]) exp_sel = ~exp_sel;
    w = IDLE_WORD;
    w[4] = exp_sel;
    chk($sformatf("v%0d_done_pulses", idx), 64'(done_cnt), 64'(1));
    if (v.busy != 0) chk($sformatf("v%0d_busy_cycles", idx), 64'(busy_cnt), 64'(v.busy));
    chk($sformatf("v%0d_writes", idx), 64'(wr_cnt), 64'(v.writes));
    chk($sformatf("v%0d_exec", idx), 64'(exec_cnt), 64'(k * v.nij));
    chk($sformatf("v%0d_load", idx), 64'(load_cnt), 64'(k * (ROW + COL)));
    chk($sformatf("v%0d_l0wr", idx), 64'(l0wr_cnt), 64'(k * (COL + v.nij)));
    chk($sformatf("v%0d_xq_left", idx), 64'(exp_x.size()), 64'(0));
    chk($sformatf("v%0d_pq_left", idx), 64'(exp_p.size()), 64'(0));
    chk($sformatf("v%0d_rd_stray", idx), 64'(rd_stray), 64'(0));
    chk($sformatf("v%0d_sel", idx), 64'(bus.sel), 64'(exp_sel));
    chk($sformatf("v%0d_mode", idx), 64'(bus.mode), 64'(v.mode));
    chk($sformatf("v%0d_busy_end", idx), 64'(bus.busy), 64'(0));
    chk($sformatf("v%0d_idle_word", idx), 64'(bus.inst), 64'(w));
    exp_x.delete();
    exp_p.delete();
  endtask

  initial begin
    bit seen;
    vecs[0] = '{1, 4, 0, 1'b0, 1'b0, 4, 18};
    vecs[1] = '{3, 2, 0, 1'b1, 1'b0, 6, 40};
    vecs[2] = '{1, 4, 1, 1'b0, 1'b0, 4, 0};
    vecs[3] = '{0, 5, 0, 1'b1, 1'b0, 0, 1};
    vecs[4] = '{2, 0, 0, 1'b0, 1'b0, 0, 1};
    vecs[5] = '{12, 1, 0, 1'b0, 1'b0, 9, 100};
    vecs[6] = '{2, 3, 2, 1'b1, 1'b0, 6, 0};
    vecs[7] = '{1, 2, 0, 1'b1, 1'b1, 2, 14};

    reset = 1'b1;
    bus.start = 1'b0;
    bus.num_kij = 4'd0;
    bus.num_nij = 11'd0;
    bus.mode_in = 1'b0;
    bus.ofifo_valid = 1'b0;
    clr();
    tick();
    tick();
    tick();
    reset = 1'b0;
    chk("rst_inst", 64'(bus.inst), 64'(IDLE_WORD));
    chk("rst_busy", 64'(bus.busy), 64'(0));
    chk("rst_done", 64'(bus.done), 64'(0));
    chk("rst_sel", 64'(bus.sel), 64'(0));
    chk("rst_mode", 64'(bus.mode), 64'(0));
`ifdef CORE_SEQ_WATCHDOG_EN
    chk("rst_err", 64'(bus.err), 64'(0));
`endif
    tick();

    for (int i = 0; i < 8; i++) run_case(vecs[i], i);

    // Reset while executing: outputs return to reset values on the next edge
    bus.num_kij = 4'd2;
    bus.num_nij = 11'd50;
    bus.mode_in = 1'b1;
    push_run(2, 50, 1'b1);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    seen = 1'b0;
    for (int cyc = 0; cyc < 100 && !seen; cyc++) begin
      if (bus.inst[1] === 1'b1) seen = 1'b1;
      else tick();
    end
    chk("mid_exec_reached", 64'(seen), 64'(1));
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_inst", 64'(bus.inst), 64'(IDLE_WORD));
    chk("mid_rst_busy", 64'(bus.busy), 64'(0));
    chk("mid_rst_sel", 64'(bus.sel), 64'(0));
    chk("mid_rst_mode", 64'(bus.mode), 64'(0));
    exp_sel = 1'b0;
    exp_x.delete();
    exp_p.delete();
    clr();
    tick();
    tick();
    chk("mid_rst_quiet", 64'(busy_cnt + done_cnt), 64'(0));
    run_case(vecs[0], 8);

`ifdef CORE_SEQ_WATCHDOG_EN
    // ofifo never valid: watchdog ends the run through FIN with err set
    bus.num_kij = 4'd1;
    bus.num_nij = 11'd2;
    bus.ofifo_valid = 1'b0;
    push_run(1, 2, 1'b0);
    clr();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    seen = 1'b0;
    for (int cyc = 0; cyc < 1500 && !seen; cyc++) begin
      if (bus.done === 1'b1) seen = 1'b1;
      else tick();
    end
    chk("wd_done_seen", 64'(seen), 64'(1));
    chk("wd_err", 64'(bus.err), 64'(1));
    tick();
    tick();
    chk("wd_busy_cycles", 64'(busy_cnt), 64'(1035));
    chk("wd_writes", 64'(wr_cnt), 64'(0));
    chk("wd_idle", 64'(bus.busy), 64'(0));
    chk("wd_err_sticky", 64'(bus.err), 64'(1));
    chk("wd_xq_left", 64'(exp_x.size()), 64'(0));
    exp_x.delete();
    bus.num_nij = 11'd0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("wd_err_clear", 64'(bus.err), 64'(0));
    tick();
    tick();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
